// File: rtl/fetch_buffer_pkg.sv
// Shared defaults and the packed entry format for the instruction fetch buffer.
package fetch_pkg;

   localparam int FETCH_INSTR_W = 18;
   localparam int FETCH_ADDR_W  = 10;
   localparam int FETCH_DEPTH   = 4;

   // One buffered fetch: instruction word travels with its own address.
   typedef struct packed {
      logic [FETCH_INSTR_W-1:0] instr;
      logic [FETCH_ADDR_W-1:0]  addr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-side and decode-side handshake bundle for fetch_buffer.
//
// Handshake semantics: a transfer happens on a rising clock edge where both
// valid and ready are 1. The fetch side offers {in_instr, in_addr} with
// in_valid and the buffer accepts when in_ready=1. The buffer presents the head
// with out_valid and decode takes it when out_ready=1. out_ready=0 stalls, and
// the head then stays stable.
interface fetch_buffer_if
   import fetch_pkg::*;
#(
   parameter int INSTR_W = FETCH_INSTR_W,
   parameter int ADDR_W  = FETCH_ADDR_W,
   parameter int DEPTH   = FETCH_DEPTH
) ();

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic               in_valid;
   logic [INSTR_W-1:0] in_instr;
   logic [ADDR_W-1:0]  in_addr;
   logic               in_ready;
   logic               out_valid;
   logic [INSTR_W-1:0] out_instr;
   logic [ADDR_W-1:0]  out_addr;
   logic               out_ready;
   logic [CNT_W-1:0]   count;

   // Buffer view.
   modport slave (
      input  in_valid, in_instr, in_addr, out_ready,
      output in_ready, out_valid, out_instr, out_addr, count
   );

   // Environment view: fetch stage plus decode stage.
   modport master (
      output in_valid, in_instr, in_addr, out_ready,
      input  in_ready, out_valid, out_instr, out_addr, count
   );

endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: a small FIFO of {instr, addr} pairs between fetch
// and decode. Flush has priority over push and pop. The head is a zero bubble
// when the buffer is empty.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int INSTR_W = FETCH_INSTR_W,
   parameter int ADDR_W  = FETCH_ADDR_W,
   parameter int DEPTH   = FETCH_DEPTH
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   fetch_buffer_if.slave   bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  addr;
   } entry_t;

   entry_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               push, pop;
   logic               not_empty;
   entry_t             head;

   assign not_empty = (count_q != '0);
   assign push      = bus.in_valid && (count_q < CNT_W'(DEPTH));
   assign pop       = bus.out_ready && not_empty;
   assign head      = mem_q[rd_ptr_q];

   // Next pointers and occupancy; a flush wipes everything and ignores push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and count registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; no reset needed because count gates visibility.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_q[wr_ptr_q] <= '{instr: bus.in_instr, addr: bus.in_addr};
      end
   end

   // Handshake outputs; the head shows as a zero bubble while the buffer is empty.
   always_comb begin
      bus.in_ready  = (count_q < CNT_W'(DEPTH));
      bus.out_valid = not_empty;
      bus.out_instr = not_empty ? head.instr : '0;
      bus.out_addr  = not_empty ? head.addr  : '0;
      bus.count     = count_q;
   end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter INSTR_W, default 18, instruction word width.
REQ-002 Parameter ADDR_W, default 10, program-counter width.
REQ-003 Parameter DEPTH, default 4, entry count; power of two, >= 2.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 flush  input  1  discard all held entries (branch taken / mispredict).
REQ-007 in_valid  input  1  fetch stage offers {in_instr, in_addr}.
REQ-008 in_instr  input  INSTR_W  fetched instruction word.
REQ-009 in_addr  input  ADDR_W  address of in_instr.
REQ-010 in_ready  output  1  buffer accepts an entry this cycle.
REQ-011 out_valid  output  1  head entry presented to decode.
REQ-012 out_instr  output  INSTR_W  head instruction; 0 when out_valid=0.
REQ-013 out_addr  output  ADDR_W  head address; 0 when out_valid=0.
REQ-014 out_ready  input  1  decode consumes head this cycle (deasserted = stall).
REQ-015 count  output  $clog2(DEPTH)+1  number of held entries.

Function
REQ-016 Push occurs when in_valid=1 and in_ready=1; pop when out_valid=1 and out_ready=1.
REQ-017 in_ready SHALL be 1 exactly when count < DEPTH; no same-cycle pass-through when full.
REQ-018 out_valid SHALL be 1 exactly when count != 0; out_instr/out_addr driven combinationally from head storage, zero (NOP bubble) otherwise.
REQ-019 Latency: a pushed entry SHALL appear on the outputs in the cycle after the push edge when the buffer was empty.
REQ-020 Entries SHALL leave in push order; the {instr, addr} pairing SHALL never be split.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-022 Read/write pointers SHALL wrap modulo DEPTH without a bubble.
REQ-023 Flush SHALL have highest priority: next cycle count=0, out_valid=0; a same-cycle push and pop SHALL both be ignored.
REQ-024 Pop with out_ready held 0 SHALL hold head outputs stable across cycles.
REQ-025 Storage contents not under the head SHALL never be visible on the outputs.

Reset
REQ-026 rst_n=0 SHALL immediately clear pointers and count, forcing out_valid=0, out_instr=0, out_addr=0, in_ready=1.
REQ-027 Reset asserted mid-operation SHALL discard all entries; the first edge after release SHALL accept a push normally.
REQ-028 Storage array SHALL NOT require reset.

Structure
REQ-029 Package fetch_pkg SHALL hold default INSTR_W, ADDR_W, DEPTH constants and a packed fetch entry typedef {instr, addr}.
REQ-030 Storage, pointers and count SHALL live in fetch_buffer; no sub-module.

Verification
REQ-031 Reset then push 0x3F0A1/addr 0x005 with out_ready=0 -> next cycle out_valid=1, out_instr=0x3F0A1, out_addr=0x005, count=1.
REQ-032 Push 4 entries, out_ready=0 -> count=4, in_ready=0; 5th offered entry dropped; drain returns entries 1..4 in order.
REQ-033 At count=2 push and pop same cycle -> count stays 2; repeat 10 cycles to exercise pointer wrap, order preserved.
REQ-034 At count=3 assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, outputs 0.
REQ-035 At count=2 drop rst_n between edges -> outputs zero before next edge; after release push addr 0x3FF -> appears with count=1.
REQ-036 DEPTH=8, INSTR_W=32 instance -> fills to count=8, in_ready=0, drains in order.
